// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad encoder: debounce FSM state encoding,
// default debounce length and one-hot digit helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESS   = 2'd1,
        ST_HELD    = 2'd2,
        ST_RELEASE = 2'd3
    } db_state_e;

    localparam int unsigned DEBOUNCE_DEFAULT = 4;

    function automatic logic [3:0] onehot10_to_bcd(input logic [9:0] v);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (v[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic is_onehot10(input logic [9:0] v);
        return $onehot(v);
    endfunction

endpackage

// File: rtl/keypad_encoder_if.sv
// Raw keypad inputs and encoded pulse outputs of keypad_encoder.
// master = stimulus/upstream side, slave = the encoder.
interface keypad_encoder_if;
    logic [9:0] key;
    logic       startn;
    logic       stopn;
    logic [3:0] bcd;
    logic       key_valid;
    logic       key_error;
    logic       start_pulse;
    logic       stop_pulse;

    modport master (
        output key, startn, stopn,
        input  bcd, key_valid, key_error, start_pulse, stop_pulse
    );

    modport slave (
        input  key, startn, stopn,
        output bcd, key_valid, key_error, start_pulse, stop_pulse
    );
endinterface

// File: rtl/key_debouncer.sv
// Parameterised-width debounce FSM. o_accept is a strobe valid in the cycle the
// accepting sample is seen; o_snap is the pattern being accepted.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned WIDTH           = 10,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_sample,
    output logic             o_accept,
    output logic [WIDTH-1:0] o_snap
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic          D_IS_ONE = (DEBOUNCE_CYCLES == 1);

    db_state_e        r_state, w_state_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_snap, w_snap_nxt;
    logic             w_nz, w_match, w_last;

    assign w_nz    = |i_sample;
    assign w_match = (i_sample == r_snap);
    assign w_last  = (r_cnt >= C_MAX - C_ONE);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_snap  <= w_snap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_snap_nxt  = r_snap;
        unique case (r_state)
            ST_IDLE: if (w_nz) begin
                w_snap_nxt  = i_sample;
                w_cnt_nxt   = C_ONE;
                w_state_nxt = D_IS_ONE ? ST_HELD : ST_PRESS;
            end
            ST_PRESS: begin
                if (!w_nz) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_match) begin
                    // cnt counts accepted samples and saturates at D
                    if (w_last) begin
                        w_cnt_nxt   = C_MAX;
                        w_state_nxt = ST_HELD;
                    end else begin
                        w_cnt_nxt = r_cnt + C_ONE;
                    end
                end else begin
                    w_snap_nxt = i_sample;
                    w_cnt_nxt  = C_ONE;
                end
            end
            ST_HELD: if (!w_nz) begin
                w_cnt_nxt   = C_ONE;
                w_state_nxt = D_IS_ONE ? ST_IDLE : ST_RELEASE;
            end
            ST_RELEASE: begin
                if (w_nz) begin
                    w_state_nxt = ST_HELD;
                end else if (w_last) begin
                    w_cnt_nxt   = C_MAX;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + C_ONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_accept = 1'b0;
        o_snap   = r_snap;
        unique case (r_state)
            ST_IDLE: begin
                o_accept = w_nz && D_IS_ONE;
                o_snap   = i_sample;
            end
            ST_PRESS: o_accept = w_nz && w_match && w_last;
            default:  o_accept = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_encoder.sv
// Debounces ten digit keys plus start/stop and emits registered one-cycle pulses.
// Define KEYPAD_SYNC_EN to add a two-flop synchronizer on every raw input.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    keypad_encoder_if.slave bus
);
    logic [9:0] w_k;
    logic       w_s, w_p;

`ifdef KEYPAD_SYNC_EN
    logic [11:0] r_sync1, r_sync2;

    // Buttons are inverted before syncing so a reset flop reads as "not pressed"
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {~bus.stopn, ~bus.startn, bus.key};
            r_sync2 <= r_sync1;
        end
    end

    assign w_k = r_sync2[9:0];
    assign w_s = r_sync2[10];
    assign w_p = r_sync2[11];
`else
    assign w_k = bus.key;
    assign w_s = ~bus.startn;
    assign w_p = ~bus.stopn;
`endif

    logic       w_key_acc, w_start_acc, w_stop_acc;
    logic [9:0] w_key_snap;
    logic       w_start_snap, w_stop_snap;
    logic       w_unused_snaps;
    logic       w_onehot;

    key_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key (
        .clock(clock), .reset(reset), .i_sample(w_k),
        .o_accept(w_key_acc), .o_snap(w_key_snap)
    );

    key_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clock(clock), .reset(reset), .i_sample(w_s),
        .o_accept(w_start_acc), .o_snap(w_start_snap)
    );

    key_debouncer #(.WIDTH(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clock(clock), .reset(reset), .i_sample(w_p),
        .o_accept(w_stop_acc), .o_snap(w_stop_snap)
    );

    assign w_unused_snaps = w_start_snap ^ w_stop_snap;
    assign w_onehot       = is_onehot10(w_key_snap);

    logic [3:0] r_bcd;
    logic       r_key_valid, r_key_error, r_start_pulse, r_stop_pulse;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_bcd         <= '0;
            r_key_valid   <= 1'b0;
            r_key_error   <= 1'b0;
            r_start_pulse <= 1'b0;
            r_stop_pulse  <= 1'b0;
        end else begin
            r_key_valid   <= w_key_acc && w_onehot;
            r_key_error   <= w_key_acc && !w_onehot;
            if (w_key_acc && w_onehot) r_bcd <= onehot10_to_bcd(w_key_snap);
            // A coincident start press is dropped; its FSM still proceeds to HELD
            r_stop_pulse  <= w_stop_acc;
            r_start_pulse <= w_start_acc && !w_stop_acc;
        end
    end

    assign bus.bcd         = r_bcd;
    assign bus.key_valid   = r_key_valid;
    assign bus.key_error   = r_key_error;
    assign bus.start_pulse = r_start_pulse;
    assign bus.stop_pulse  = r_stop_pulse;

endmodule
